// File: rtl/pc_sequencer.sv
// pc_sequencer: 8-bit program-counter next-address controller (BOOT/RUN/HALT).
// Define PC_SEQ_RAS_EN to build the return-address stack used by call/ret.
module pc_sequencer #(
    parameter logic [7:0]  RESET_VEC = 8'h00,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       halt,
    input  logic       resume,
    input  logic       branch_taken,
    input  logic [7:0] branch_off,
    input  logic       jump,
    input  logic       call,
    input  logic       ret,
    input  logic [7:0] jump_addr,
    output logic [7:0] pc,
    output logic       fetch_en,
    output logic       halted,
    output logic       ras_err
);

    localparam int unsigned PC_W = 8;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] ret_target;
    logic            run_act;
    logic            ret_act;
    logic            ras_err_set;

    if ((RAS_DEPTH < 2) || (RAS_DEPTH > 16) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
    end

    // Offset and PC share a width, so modulo-256 addition is the sign-extended add.
    assign pc_inc  = pc + PC_W'(1);
    assign pc_br   = pc + branch_off;
    assign run_act = (state == ST_RUN) && !stall;
    assign ret_act = run_act && !halt && ret;

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [IDX_W-1:0] top_idx;
    logic             ras_empty;
    logic             ras_full;
    logic             call_act;
    logic             ras_push;
    logic             ras_pop;

    assign ras_empty   = (ras_ptr == '0);
    assign ras_full    = (ras_ptr == PTR_W'(RAS_DEPTH));
    assign call_act    = run_act && !halt && !ret && call;
    assign ras_push    = call_act && !ras_full;
    assign ras_pop     = ret_act && !ras_empty;
    assign top_idx     = IDX_W'(ras_ptr - PTR_W'(1));
    assign ret_target  = ras_empty ? pc_inc : ras_mem[top_idx];
    assign ras_err_set = (ret_act && ras_empty) || (call_act && ras_full);

    // Stack contents carry no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[IDX_W'(ras_ptr)] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_W'(1);
        end
    end
`else
    // Without a stack every return is an underflow.
    assign ret_target  = pc_inc;
    assign ras_err_set = ret_act;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_VEC;
            fetch_en <= 1'b0;
            halted   <= 1'b0;
            ras_err  <= 1'b0;
        end else begin
            if (ras_err_set) begin
                ras_err <= 1'b1;
            end
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    fetch_en <= 1'b1;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            pc       <= pc_inc;
                            state    <= ST_HALT;
                            fetch_en <= 1'b0;
                            halted   <= 1'b1;
                        end else if (ret) begin
                            pc <= ret_target;
                        end else if (call || jump) begin
                            pc <= jump_addr;
                        end else if (branch_taken) begin
                            pc <= pc_br;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state    <= ST_RUN;
                        fetch_en <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    fetch_en <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
